// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for one pipeline stage boundary (upstream in_* side, downstream out_* side).
// master drives the payload toward the stage; slave is the stage itself.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 96
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register: valid/ready on both sides, optional skid entry,
// flush that kills in-flight entries, saturating stall/flush counters.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W     = 96,
    parameter bit                SKID_EN    = 1'b1,
    parameter logic [DATA_W-1:0] FLUSH_DATA = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_m_q, valid_m_d;
    logic [DATA_W-1:0] data_m_q,  data_m_d;
    logic              valid_s_q, valid_s_d;
    logic [DATA_W-1:0] data_s_q,  data_s_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic in_ready_c;
    logic in_fire_c;
    logic out_fire_c;

    // With a skid entry in_ready depends only on state; without it, it looks through to out_ready.
    assign in_ready_c = SKID_EN ? !valid_s_q : (!valid_m_q || bus.out_ready);
    assign in_fire_c  = bus.in_valid && in_ready_c && !flush;
    assign out_fire_c = valid_m_q && bus.out_ready;

    // Entry next-state; data_m returns to FLUSH_DATA whenever main empties so out_data is a plain flop.
    always_comb begin
        valid_m_d = valid_m_q;
        data_m_d  = data_m_q;
        valid_s_d = valid_s_q;
        data_s_d  = data_s_q;

        if (flush) begin
            valid_m_d = 1'b0;
            valid_s_d = 1'b0;
            data_m_d  = FLUSH_DATA;
        end else if (SKID_EN) begin
            if (out_fire_c || !valid_m_q) begin
                if (valid_s_q) begin
                    valid_m_d = 1'b1;
                    data_m_d  = data_s_q;
                    valid_s_d = in_fire_c;
                    if (in_fire_c) begin
                        data_s_d = bus.in_data;
                    end
                end else if (in_fire_c) begin
                    valid_m_d = 1'b1;
                    data_m_d  = bus.in_data;
                end else begin
                    valid_m_d = 1'b0;
                    data_m_d  = FLUSH_DATA;
                end
            end else if (in_fire_c) begin
                valid_s_d = 1'b1;
                data_s_d  = bus.in_data;
            end
        end else begin
            if (in_fire_c) begin
                valid_m_d = 1'b1;
                data_m_d  = bus.in_data;
            end else if (out_fire_c) begin
                valid_m_d = 1'b0;
                data_m_d  = FLUSH_DATA;
            end
        end
    end

    // Saturating performance counters; a stall in a flush cycle still counts.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (valid_m_q && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_m_q   <= 1'b0;
            data_m_q    <= FLUSH_DATA;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_m_q   <= valid_m_d;
            data_m_q    <= data_m_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    if (SKID_EN) begin : g_skid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_s_q <= 1'b0;
                data_s_q  <= '0;
            end else begin
                valid_s_q <= valid_s_d;
                data_s_q  <= data_s_d;
            end
        end
    end else begin : g_no_skid
        assign valid_s_q = 1'b0;
        assign data_s_q  = '0;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_m_q;
    assign bus.out_data  = data_m_q;
    assign occupancy     = 2'(valid_m_q) + 2'(valid_s_q);
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register with a valid/ready handshake on both sides.
- Replaces fixed-field inter-stage registers: one generic block per stage boundary (F/D, D/E, E/M, M/W).
- Adds an optional skid entry for full throughput under back-pressure, a flush that kills in-flight entries, and saturating stall/flush counters.
- Data is an opaque packed vector; the instantiating stage packs instr/pc/pcplus4 etc.

Parameters:
- DATA_W, 96, width of the payload vector.
- SKID_EN, 1, 1 = two-entry (main + skid) buffer with registered in_ready; 0 = single entry with combinational in_ready.
- FLUSH_DATA, 0 (DATA_W'b0), value driven on out_data when the main entry is empty; also the reset/flush value of the main data register.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  kill all entries; highest priority after reset.
- in_valid  in  1  upstream has data.
- in_ready  out  1  stage can accept data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds valid data.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  main entry payload, or FLUSH_DATA when empty.
- occupancy  out  2  number of valid entries (0..2; max 1 when SKID_EN=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- flush_cnt  out  CNT_W  cycles with flush=1, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n (clk, rst_n).
- Reset (async on rst_n=0):
  - valid_m=0, valid_s=0, data_m=FLUSH_DATA, data_s=0.
  - stall_cnt=0, flush_cnt=0.
  - Therefore out_valid=0, out_data=FLUSH_DATA, occupancy=0.
  - in_ready=1 (SKID_EN=1) or 1 via the comb term (SKID_EN=0).
- Handshake terms:
  - in_fire = in_valid & in_ready & !flush.
  - out_fire = out_valid & out_ready.
  - Payload is sampled only on in_fire.
  - Once out_valid=1 is presented, data is held stable until out_fire or flush.
- SKID_EN=1:
  - in_ready = !valid_s (registered, no comb path from out_ready).
  - Main free next cycle (out_fire | !valid_m):
    - If valid_s, M<-S and S is cleared; in_fire in the same cycle loads S.
    - Otherwise M<-input on in_fire, else valid_m<=0.
  - Main held (valid_m & !out_ready): in_fire loads S.
  - FIFO order is always preserved; the skid entry never overtakes the main entry.
  - Full-throughput case: with out_ready=1 continuously, one transfer per cycle and S stays empty.
- SKID_EN=0:
  - in_ready = !valid_m | out_ready (comb).
  - On in_fire, M<-input; on out_fire without in_fire, valid_m<=0.
  - Skid registers are not generated; occupancy[1]=0.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- flush=1 at a clock edge:
  - valid_m<=0, valid_s<=0, data_m<=FLUSH_DATA.
  - Input offered that cycle is dropped, even if in_ready=1.
  - An out_fire in the same cycle still counts as delivered downstream (downstream sampled it).
- Counters:
  - stall_cnt increments on each cycle where out_valid & !out_ready (flush cycles included).
  - flush_cnt increments on each cycle flush=1.
  - Both hold at 2^CNT_W-1; no wrap.
- occupancy = valid_m + valid_s, registered-state derived.
- Reset mid-transfer: all state clears immediately (async); no handshake completes in that cycle.

Test Plan:
- Reset and empty output: SKID_EN=1, rst_n=0 asynchronously mid-cycle with valid_m=1 -> out_valid=0, out_data=FLUSH_DATA, occupancy=0, in_ready=1 before the next edge.
- Streaming: in_valid=1, out_ready=1, data 0x1,0x2,...,0x10 on consecutive cycles -> out_data 0x1..0x10 one per cycle starting 1 cycle later, occupancy never exceeds 1, stall_cnt=0.
- Back-pressure and skid: send A, B while out_ready=0 -> occupancy=2, in_ready=0, C held upstream. Release out_ready -> outputs A,B,C in order with no loss or duplicates. stall_cnt equals the number of stalled cycles.
- Flush with occupancy=2 and in_valid=1 (D): flush for 1 cycle -> next cycle out_valid=0, out_data=FLUSH_DATA, occupancy=0, D never appears, flush_cnt=1. Next input E appears after 1 cycle.
- SKID_EN=0 comb path: valid_m=1, out_ready toggling 0/1 with in_valid=1 -> in_ready equals out_ready each cycle, one-per-cycle transfer when out_ready=1, no data loss.
- Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Same check with flush held for 20 cycles -> flush_cnt stops at 15.
